// File: rtl/msu_audio_fetch.sv
// msu_audio_fetch: fetches 128-word audio sectors from a host into a FIFO.
// Ports: clk/reset_n (sync, active-low); play_i/repeat_i/track_*_i/loop_pt_i
//   track control; sec_req_o/sec_lba_o/sec_ack_i sector handshake;
//   in_valid_i/in_data_i sector words; fifo_clr_o/fifo_wrreq_o/fifo_data_o/
//   fifo_wrusedw_i FIFO write side; playing_o/ended_o status.
// Optional macro MSU_AUDIO_LOOP_EN: honour loop_pt_i on repeat.
module msu_audio_fetch #(
   parameter int DEPTH       = 11,
   parameter int FILL_THRESH = 1792
) (
   input  logic             clk,
   input  logic             reset_n,
   input  logic             play_i,
   input  logic             repeat_i,
   input  logic [31:0]      track_base_i,
   input  logic [31:0]      track_len_i,
   input  logic [31:0]      loop_pt_i,
   output logic             sec_req_o,
   output logic [31:0]      sec_lba_o,
   input  logic             sec_ack_i,
   input  logic             in_valid_i,
   input  logic [31:0]      in_data_i,
   output logic             fifo_clr_o,
   output logic             fifo_wrreq_o,
   output logic [31:0]      fifo_data_o,
   input  logic [DEPTH-1:0] fifo_wrusedw_i,
   output logic             playing_o,
   output logic             ended_o
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_CLR   = 3'd1;
   localparam logic [2:0] S_WAIT  = 3'd2;
   localparam logic [2:0] S_REQ   = 3'd3;
   localparam logic [2:0] S_XFER  = 3'd4;
   localparam logic [2:0] S_DRAIN = 3'd5;

   localparam logic [31:0] THRESH = 32'(FILL_THRESH);

   // A whole sector must always fit once a fetch has been started.
   if (FILL_THRESH > (2 ** DEPTH) - 129) begin : g_thresh_chk
      $error("FILL_THRESH leaves no room for a 128-word sector");
   end

   logic [2:0]  state_q, state_d;
   logic        play_q;
   logic [31:0] base_q, base_d;
   logic [31:0] len_q, len_d;
   logic [31:0] loop_q, loop_d;
   logic [31:0] pos_q, pos_d;
   logic [31:0] lba_q, lba_d;
   logic [6:0]  skip_q, skip_d;
   logic [6:0]  w_q, w_d;
   logic [7:0]  outst_q, outst_d;
   logic        pend_q, pend_d;
   logic        ended_q, ended_d;

   logic        play_rise;
   logic        fill_ok;
   logic        in_track;
   logic        wr;
   logic [31:0] lp;

   assign play_rise = play_i & ~play_q;
   assign fill_ok   = 32'(fifo_wrusedw_i) <= THRESH;
   assign in_track  = pos_q < len_q;
   assign wr        = (state_q == S_XFER) & play_i & in_valid_i &
                      (w_q >= skip_q) & in_track;

`ifdef MSU_AUDIO_LOOP_EN
   // Out-of-range loop points restart from the track start.
   assign lp = (loop_q >= len_q) ? 32'd0 : loop_q;
`else
   logic loop_unused;
   assign lp          = 32'd0;
   assign loop_unused = ^loop_q;
`endif

   always_comb begin
      state_d = state_q;
      base_d  = base_q;
      len_d   = len_q;
      loop_d  = loop_q;
      pos_d   = pos_q;
      lba_d   = lba_q;
      skip_d  = skip_q;
      w_d     = w_q;
      outst_d = outst_q;
      pend_d  = pend_q;
      ended_d = ended_q;

      if (play_rise) begin
         base_d  = track_base_i;
         len_d   = track_len_i;
         loop_d  = loop_pt_i;
         ended_d = 1'b0;
      end

      // Words still owed by the host, counted even after a stop so a
      // restart cannot mix stale words into the fresh FIFO.
      if (state_q == S_REQ && sec_ack_i) begin
         outst_d = 8'd128;
      end else if (in_valid_i && outst_q != 8'd0) begin
         outst_d = outst_q - 8'd1;
      end

      if (state_q != S_IDLE && !play_i) begin
         state_d = S_IDLE;
      end else begin
         case (state_q)
            S_IDLE: begin
               if (!play_i) begin
                  pend_d = 1'b0;
               end else if (play_rise || pend_q) begin
                  if (outst_q == 8'd0) begin
                     state_d = S_CLR;
                     pend_d  = 1'b0;
                  end else begin
                     pend_d = 1'b1;
                  end
               end
            end
            S_CLR: begin
               pos_d   = 32'd0;
               lba_d   = base_q;
               skip_d  = 7'd0;
               state_d = S_WAIT;
            end
            S_WAIT: begin
               if (!in_track) begin
                  state_d = S_DRAIN;
               end else if (fill_ok) begin
                  state_d = S_REQ;
               end
            end
            S_REQ: begin
               if (sec_ack_i) begin
                  w_d     = 7'd0;
                  state_d = S_XFER;
               end
            end
            S_XFER: begin
               if (in_valid_i) begin
                  w_d = w_q + 7'd1;
                  if (wr) begin
                     pos_d = pos_q + 32'd1;
                  end
                  if (w_q == 7'd127) begin
                     lba_d   = lba_q + 32'd1;
                     skip_d  = 7'd0;
                     state_d = S_WAIT;
                  end
               end
            end
            S_DRAIN: begin
               if (repeat_i) begin
                  pos_d   = lp;
                  lba_d   = base_q + (lp >> 7);
                  skip_d  = lp[6:0];
                  state_d = S_WAIT;
               end else begin
                  ended_d = 1'b1;
                  state_d = S_IDLE;
               end
            end
            default: state_d = S_IDLE;
         endcase
      end
   end

   always_ff @(posedge clk) begin
      if (!reset_n) begin
         state_q <= S_IDLE;
         play_q  <= 1'b0;
         base_q  <= 32'd0;
         len_q   <= 32'd0;
         loop_q  <= 32'd0;
         pos_q   <= 32'd0;
         lba_q   <= 32'd0;
         skip_q  <= 7'd0;
         w_q     <= 7'd0;
         outst_q <= 8'd0;
         pend_q  <= 1'b0;
         ended_q <= 1'b0;
      end else begin
         state_q <= state_d;
         play_q  <= play_i;
         base_q  <= base_d;
         len_q   <= len_d;
         loop_q  <= loop_d;
         pos_q   <= pos_d;
         lba_q   <= lba_d;
         skip_q  <= skip_d;
         w_q     <= w_d;
         outst_q <= outst_d;
         pend_q  <= pend_d;
         ended_q <= ended_d;
      end
   end

   assign sec_req_o    = state_q == S_REQ;
   assign sec_lba_o    = lba_q;
   assign fifo_clr_o   = state_q == S_CLR;
   assign fifo_wrreq_o = wr & reset_n;
   assign fifo_data_o  = fifo_wrreq_o ? in_data_i : 32'd0;
   assign playing_o    = state_q != S_IDLE;
   assign ended_o      = ended_q;

endmodule
